// File: rtl/recon_row.sv
// recon_row: rebuilds pixel rows as CUR + residual, clipped to the pixel range.
// Two-stage valid/ready pipeline with 8x8 block row tracking and clip counting.
module recon_row #(
  parameter int ROWS_PER_BLOCK = 8,
  parameter int PIX_W          = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ena,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [8*PIX_W-1:0]                CUR,
  input  logic signed [PIX_W:0]             diff_0,
  input  logic signed [PIX_W:0]             diff_1,
  input  logic signed [PIX_W:0]             diff_2,
  input  logic signed [PIX_W:0]             diff_3,
  input  logic signed [PIX_W:0]             diff_4,
  input  logic signed [PIX_W:0]             diff_5,
  input  logic signed [PIX_W:0]             diff_6,
  input  logic signed [PIX_W:0]             diff_7,
  output logic [8*PIX_W-1:0]                REC,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(ROWS_PER_BLOCK)-1:0] row_idx,
  output logic                              block_done,
  output logic [6:0]                        clip_cnt
);

  localparam int SW = PIX_W + 3;
  localparam int RW = $clog2(ROWS_PER_BLOCK);
  localparam logic [RW-1:0] LAST = RW'(ROWS_PER_BLOCK - 1);
  localparam logic signed [SW-1:0] PMAX = SW'((1 << PIX_W) - 1);

  logic signed [PIX_W:0]  diff [8];
  logic signed [SW-1:0]   sum_d [8];
  logic signed [SW-1:0]   s1_sum [8];
  logic                   s1_valid;
  logic                   stall;
  logic                   accept;
  logic [8*PIX_W-1:0]     rec_d;
  logic [3:0]             nclip;
  logic [RW-1:0]          blk_row;
  logic [RW-1:0]          blk_nxt;
  logic [6:0]             clip_base;

  assign diff[0] = diff_0;
  assign diff[1] = diff_1;
  assign diff[2] = diff_2;
  assign diff[3] = diff_3;
  assign diff[4] = diff_4;
  assign diff[5] = diff_5;
  assign diff[6] = diff_6;
  assign diff[7] = diff_7;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ena & ~stall;
  assign accept   = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sum_d[i] = $signed({3'b000, CUR[i*PIX_W +: PIX_W]}) + SW'(diff[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < 8; i++) s1_sum[i] <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) s1_sum <= sum_d;
    end
  end

  // Saturate each sum and count how many pixels hit a rail.
  always_comb begin
    rec_d = '0;
    nclip = '0;
    for (int i = 0; i < 8; i++) begin
      if (s1_sum[i][SW-1]) begin
        rec_d[i*PIX_W +: PIX_W] = '0;
        nclip = nclip + 4'd1;
      end else if (s1_sum[i] > PMAX) begin
        rec_d[i*PIX_W +: PIX_W] = '1;
        nclip = nclip + 4'd1;
      end else begin
        rec_d[i*PIX_W +: PIX_W] = s1_sum[i][PIX_W-1:0];
      end
    end
  end

  assign blk_nxt   = (blk_row == LAST) ? '0 : blk_row + RW'(1);
  assign clip_base = (blk_row == '0) ? 7'd0 : clip_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      REC       <= '0;
      row_idx   <= '0;
      clip_cnt  <= '0;
      blk_row   <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        REC      <= rec_d;
        row_idx  <= blk_row;
        clip_cnt <= clip_base + 7'(nclip);
        blk_row  <= blk_nxt;
      end
    end
  end

  assign block_done = out_valid & (row_idx == LAST);

endmodule

// File: tb/tb_recon_row.sv
// tb_recon_row: table vectors plus hand sequences for recon_row.
// Expected rows go to a scoreboard queue at acceptance and are checked on output.
module tb_recon_row;

  typedef struct {
    string       name;
    logic [63:0] cur;
    logic [71:0] df;
    logic [63:0] rec;
    int          n;
  } vec_t;

  typedef struct packed {
    logic [63:0] rec;
    logic [2:0]  row;
    logic [6:0]  clip;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ena, in_valid, out_ready;
  logic        in_ready, out_valid, block_done;
  logic [63:0] CUR, REC;
  logic [71:0] dflat;
  logic [2:0]  row_idx;
  logic [6:0]  clip_cnt;

  int   nvec = 0;
  int   nerr = 0;
  int   npush = 0;
  int   npop = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [2:0] m_row;
  logic [6:0] m_clip;
  vec_t tbl[7];

  always #5 clk = ~clk;

  recon_row dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready),
    .CUR(CUR),
    .diff_0(dflat[8:0]),   .diff_1(dflat[17:9]),
    .diff_2(dflat[26:18]), .diff_3(dflat[35:27]),
    .diff_4(dflat[44:36]), .diff_5(dflat[53:45]),
    .diff_6(dflat[62:54]), .diff_7(dflat[71:63]),
    .REC(REC), .out_valid(out_valid), .out_ready(out_ready),
    .row_idx(row_idx), .block_done(block_done), .clip_cnt(clip_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] dsame(input int v);
    logic [8:0] d;
    d = 9'(v);
    return {8{d}};
  endfunction

  function automatic logic [71:0] rt_diff(input logic [63:0] cur,
                                          input logic [63:0] org);
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r[9*i +: 9] = 9'(int'(org[8*i +: 8]) - int'(cur[8*i +: 8]));
    return r;
  endfunction

  task automatic ref_row(input logic [63:0] cur, input logic [71:0] df,
                         output logic [63:0] rec, output int n);
    int s;
    rec = '0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      s = int'(cur[8*i +: 8]) + int'($signed(df[9*i +: 9]));
      if (s < 0) begin s = 0; n++; end
      else if (s > 255) begin s = 255; n++; end
      rec[8*i +: 8] = 8'(s);
    end
  endtask

  task automatic push_exp(input logic [63:0] rec, input int n);
    exp_t e;
    e.rec  = rec;
    e.row  = m_row;
    e.clip = ((m_row == 3'd0) ? 7'd0 : m_clip) + 7'(n);
    e.done = (m_row == 3'd7);
    m_clip = e.clip;
    m_row  = m_row + 3'd1;
    sb.push_back(e);
    npush++;
  endtask

  // Holds the row on the inputs until an edge accepts it.
  task automatic send(input logic [63:0] cur, input logic [71:0] df,
                      input logic [63:0] rec, input int n);
    bit ok;
    ok = 1'b0;
    CUR = cur;
    dflat = df;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (ok) push_exp(rec, n);
    else begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout: got in_ready=0 required accept");
    end
  endtask

  task automatic send_ref(input logic [63:0] cur, input logic [71:0] df);
    logic [63:0] r;
    int n;
    ref_row(cur, df, r, n);
    send(cur, df, r, n);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    sb.delete();
    m_row = '0;
    m_clip = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_row: got REC %h required none", REC);
      end else begin
        mon_e = sb.pop_front();
        npop++;
        chk("rec", REC, mon_e.rec);
        chk("row_idx", 64'(row_idx), 64'(mon_e.row));
        chk("clip_cnt", 64'(clip_cnt), 64'(mon_e.clip));
        chk("block_done", 64'(block_done), 64'(mon_e.done));
      end
    end
  end

  initial begin
    logic [63:0] hold_rec;
    logic [2:0]  hold_row;
    logic [71:0] d;
    bit seen;

    tbl[0] = '{"basic", 64'h8080808080808080, dsame(10),
               64'h8A8A8A8A8A8A8A8A, 0};
    d = dsame(0);
    d[8:0]  = 9'd255;
    d[17:9] = 9'h100;
    tbl[1] = '{"clip", 64'h404040404040_05F0, d,
               64'h404040404040_00FF, 2};
    tbl[2] = '{"round_trip", 64'hCB723BB0D6A38AC9,
               rt_diff(64'hCB723BB0D6A38AC9, 64'h36ADEB33333BDB49),
               64'h36ADEB33333BDB49, 0};
    tbl[3] = '{"underflow", 64'h0, dsame(-1), 64'h0, 8};
    tbl[4] = '{"overflow", {8{8'hFF}}, dsame(1), {8{8'hFF}}, 8};
    tbl[5] = '{"top_edge", {8{8'h7F}}, dsame(128), {8{8'hFF}}, 0};
    tbl[6] = '{"bot_edge", {8{8'h80}}, dsame(-128), 64'h0, 0};

    rst = 1'b0;
    ena = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    CUR = '0;
    dflat = '0;
    m_row = '0;
    m_clip = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_rec", REC, 64'd0);
    chk("rst_row_idx", 64'(row_idx), 64'd0);
    chk("rst_clip_cnt", 64'(clip_cnt), 64'd0);
    chk("rst_block_done", 64'(block_done), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Latency: one edge to S1, the next to the output register.
    CUR = 64'h8080808080808080;
    dflat = dsame(10);
    in_valid = 1'b1;
    chk("lat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    push_exp(64'h8A8A8A8A8A8A8A8A, 0);
    idle();
    chk("lat_after_1_edge", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_after_2_edges", 64'(out_valid), 64'd1);
    chk("lat_rec", REC, 64'h8A8A8A8A8A8A8A8A);
    drain();

    do_reset();
    for (int i = 0; i < 7; i++)
      send(tbl[i].cur, tbl[i].df, tbl[i].rec, tbl[i].n);
    idle();
    drain();

    // Nine rows back to back cross a block boundary.
    do_reset();
    for (int i = 0; i < 9; i++)
      send_ref({$urandom, $urandom}, {8'($urandom), $urandom, $urandom});
    idle();
    drain();

    // Backpressure with the sink stalled from the first output.
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_ref({$urandom, $urandom}, {8'($urandom), $urandom, $urandom});
        idle();
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          seen = out_valid;
        end
        chk("bp_first_valid", 64'(seen), 64'd1);
        hold_rec = REC;
        hold_row = row_idx;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_rec_hold", REC, hold_rec);
          chk("bp_row_hold", 64'(row_idx), 64'(hold_row));
          chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Enable low blocks input; reset discards rows in flight.
    ena = 1'b0;
    CUR = 64'h1122334455667788;
    dflat = dsame(3);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ena_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    chk("ena_no_output", 64'(out_valid), 64'd0);
    idle();
    ena = 1'b1;
    send_ref(64'h0102030405060708, dsame(5));
    send_ref(64'h1112131415161718, dsame(-5));
    rst = 1'b0;
    idle();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    sb.delete();
    npush = npop;
    m_row = '0;
    m_clip = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_no_ghost", 64'(out_valid), 64'd0);
    send_ref(64'hA0A0A0A0A0A0A0A0, dsame(-200));
    idle();
    @(posedge clk);
    #1;
    chk("midrst_row_idx", 64'(row_idx), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd1);
    drain();

    chk("rows_in_out", 64'(npop), 64'(npush));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
